sclk_tone_gen: RTL and testbench

SCLK_TONE_GEN -- requirements
Module: sclk_tone_gen

---
 rtl/sclk_tone_gen.sv | 57 +++++
 tb/tb_sclk_tone_gen.sv | 106 ++++++++++
 2 files changed

// File: rtl/sclk_tone_gen.sv
// sclk_tone_gen: square-wave tone divider whose half-period follows a debounced MAXCOUNT,
// switching only on toggle clocks so no half-period is ever truncated.
module sclk_tone_gen #(
   parameter int STABLE_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] maxcount,
   output logic        sclk,
   output logic        toggle,
   output logic [15:0] active_mc
);
   localparam int SW = $clog2(STABLE_CYCLES + 1);
   logic [SW-1:0] stab;
   logic [15:0]   cand;
   logic [15:0]   cnt;
   logic          pending;
   logic          run;
   logic          tick;
   assign pending = (stab == SW'(STABLE_CYCLES)) && (cand != active_mc);
   assign run     = en && (active_mc != 16'd0);
   assign tick    = run && (cnt == active_mc - 16'd1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand <= '0;
         stab <= '0;
      end else if (maxcount != cand) begin
         cand <= maxcount;
         stab <= '0;
      end else if (stab != SW'(STABLE_CYCLES)) begin
         stab <= stab + SW'(1);
      end
   end
   // a zero candidate is only taken on the falling edge so the tone always ends low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         sclk      <= 1'b0;
         toggle    <= 1'b0;
         active_mc <= '0;
      end else if (!run) begin
         cnt    <= '0;
         sclk   <= 1'b0;
         toggle <= sclk;
         if (pending) active_mc <= cand;
      end else if (tick) begin
         cnt    <= '0;
         sclk   <= ~sclk;
         toggle <= 1'b1;
         if (pending && (cand != 16'd0 || sclk)) active_mc <= cand;
      end else begin
         cnt    <= cnt + 16'd1;
         toggle <= 1'b0;
      end
   end
endmodule

// File: tb/tb_sclk_tone_gen.sv
// tb_sclk_tone_gen: cycle-by-cycle directed vectors for sclk_tone_gen with STABLE_CYCLES=4.
module tb_sclk_tone_gen;
   typedef struct {
      logic        en;
      logic [15:0] mc;
      logic        s;
      logic        t;
      logic [15:0] a;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [15:0] maxcount = '0;
   logic        sclk;
   logic        toggle;
   logic [15:0] active_mc;
   int          errors = 0;
   int          checks = 0;
   vec_t        tbl[$];
   sclk_tone_gen #(.STABLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .en(en), .maxcount(maxcount),
      .sclk(sclk), .toggle(toggle), .active_mc(active_mc)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int step, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s step %0d: got %0d want %0d", name, step, got, want);
      end
   endtask
   task automatic add(input int n, input logic e, input int mc, input logic s, input logic t, input int a);
      vec_t v;
      v.en = e; v.mc = 16'(mc); v.s = s; v.t = t; v.a = 16'(a);
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask
   task automatic apply(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         en = tbl[i].en;
         maxcount = tbl[i].mc;
         @(posedge clk);
         #1;
         chk("sclk", i + 1, int'(sclk), int'(tbl[i].s));
         chk("toggle", i + 1, int'(toggle), int'(tbl[i].t));
         chk("active_mc", i + 1, int'(active_mc), int'(tbl[i].a));
         @(negedge clk);
      end
   endtask
   initial begin
      // load 3 after qualification, run at 3
      add(5, 1, 3, 0, 0, 0);
      add(3, 1, 3, 0, 0, 3);
      add(1, 1, 3, 1, 1, 3);
      add(2, 1, 3, 1, 0, 3);
      add(1, 1, 3, 0, 1, 3);
      add(2, 1, 3, 0, 0, 3);
      add(1, 1, 3, 1, 1, 3);
      // 2-clock glitch to 5 is never accepted
      add(2, 1, 5, 1, 0, 3);
      add(1, 1, 3, 0, 1, 3);
      add(2, 1, 3, 0, 0, 3);
      add(1, 1, 3, 1, 1, 3);
      // 3 -> 5 loads on the first toggle after qualification
      add(2, 1, 5, 1, 0, 3);
      add(1, 1, 5, 0, 1, 3);
      add(2, 1, 5, 0, 0, 3);
      add(1, 1, 5, 1, 1, 5);
      add(4, 1, 5, 1, 0, 5);
      add(1, 1, 5, 0, 1, 5);
      // 5 -> 0 while low: finish low, one high half, fall, silence
      add(4, 1, 0, 0, 0, 5);
      add(1, 1, 0, 1, 1, 5);
      add(4, 1, 0, 1, 0, 5);
      add(1, 1, 0, 0, 1, 0);
      add(2, 1, 0, 0, 0, 0);
      // load 4, then EN drop while high and re-enable
      add(5, 1, 4, 0, 0, 0);
      add(4, 1, 4, 0, 0, 4);
      add(1, 1, 4, 1, 1, 4);
      add(1, 0, 4, 0, 1, 4);
      add(1, 0, 4, 0, 0, 4);
      add(3, 1, 4, 0, 0, 4);
      add(1, 1, 4, 1, 1, 4);
      #3;
      chk("reset_sclk", 0, int'(sclk), 0);
      chk("reset_toggle", 0, int'(toggle), 0);
      chk("reset_active", 0, int'(active_mc), 0);
      @(negedge clk);
      rst = 1'b0;
      apply(0, tbl.size() - 1);
      // asynchronous reset while SCLK is high, observed before the next edge
      @(posedge clk);
      #1;
      chk("pre_rst_sclk", 61, int'(sclk), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_sclk", 61, int'(sclk), 0);
      chk("async_rst_toggle", 61, int'(toggle), 0);
      chk("async_rst_active", 61, int'(active_mc), 0);
      @(negedge clk);
      rst = 1'b0;
      apply(0, 14);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
